unit_output_rx: RTL

- Receiving end of the bcrypt unit's 1-bit serial result output.
- The block drives the unit's `output_cnt` bit index and samples the unit's `out` bit.
- It reassembles each (MSB+1)-bit result word, LSB first, and buffers up to two words for the core's output arbiter.
- It sits between the unit's Ltmp read-out and the core output mux; a word handshake lets the core controller reload Ltmp once a word has been fully read.

---
 rtl/unit_output_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/unit_output_rx.sv
`default_nettype none
// ============================================================================
//  Module   : unit_output_rx
//  Purpose  : Receives a bcrypt unit's 1-bit serial result. Sweeps the unit's
//             output_cnt bit index, samples the returned bit (after IN_DELAY
//             register stages), reassembles each 32-bit word LSB first and
//             queues up to two words for the core output arbiter.
//  Ports    : CLK, RST          clock, asynchronous active-high reset
//             word_valid        unit Ltmp holds a word to read (held to ack)
//             word_ack          one-cycle pulse, word captured
//             output_cnt [4:0]  bit index driven to the unit
//             din               unit out bit, IN_DELAY stages late
//             dout [MSB:0]      head-of-buffer word
//             dout_valid        buffer not empty
//             rd_en             pop head word (ignored when empty)
//             busy              sweep in progress (state != IDLE)
//  Revision : 1.0  initial release
// ============================================================================
module unit_output_rx #(
  parameter int MSB      = 31,
  parameter int IN_DELAY = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         word_valid,
  output logic         word_ack,
  output logic [4:0]   output_cnt,
  input  logic         din,
  output logic [MSB:0] dout,
  output logic         dout_valid,
  input  logic         rd_en,
  output logic         busy
);

  // Extra cycles spent in DRAIN beyond the first (DRAIN lasts IN_DELAY-1).
  localparam logic [1:0] c_drain_init = 2'((IN_DELAY >= 2) ? (IN_DELAY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t       state_q;
  logic [4:0]   output_cnt_q;
  logic         word_ack_q;
  logic [1:0]   drain_q;
  logic [MSB:0] sh_q;
  logic         w_sample;
  logic [MSB:0] w_word;

  // FIFO storage
  logic [MSB:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         w_push;
  logic         w_pop;

  // --------------------------------------------------------------------------
  // Sample enable: SHIFT state delayed to line up with the returning bit.
  // --------------------------------------------------------------------------
  if (IN_DELAY == 0) begin : g_no_delay
    assign w_sample = (state_q == SHIFT);
  end else begin : g_delay
    logic [IN_DELAY-1:0] en_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        en_q <= '0;
      end else begin
        en_q[0] <= (state_q == SHIFT);
        for (int i = 1; i < IN_DELAY; i++) begin
          en_q[i] <= en_q[i-1];
        end
      end
    end
    assign w_sample = en_q[IN_DELAY-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_q <= '0;
    end else if (w_sample) begin
      sh_q <= {din, sh_q[MSB:1]};
    end
  end

  // The last bit arrives in the push cycle, so it is forwarded from din.
  assign w_word = {din, sh_q[MSB:1]};

  // --------------------------------------------------------------------------
  // Sweep FSM. word_ack_q is raised for exactly the cycle in which the final
  // sample lands; with no input delay that is the output_cnt=31 SHIFT cycle
  // and PUSH is only a one-cycle turnaround.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      output_cnt_q <= '0;
      word_ack_q   <= 1'b0;
      drain_q      <= '0;
    end else begin
      word_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (word_valid && (count_q != 2'd2)) begin
            state_q      <= SHIFT;
            output_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (output_cnt_q == 5'd31) begin
            output_cnt_q <= '0;
            if (IN_DELAY <= 1) begin
              state_q    <= PUSH;
              word_ack_q <= (IN_DELAY == 1);
            end else begin
              state_q <= DRAIN;
              drain_q <= c_drain_init;
            end
          end else begin
            output_cnt_q <= output_cnt_q + 5'd1;
            if ((IN_DELAY == 0) && (output_cnt_q == 5'd30)) begin
              word_ack_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 2'd0) begin
            state_q    <= PUSH;
            word_ack_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        PUSH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Two-entry output FIFO
  // --------------------------------------------------------------------------
  assign w_push = word_ack_q;
  assign w_pop  = rd_en && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign word_ack   = word_ack_q;
  assign output_cnt = output_cnt_q;
  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != 2'd0);
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
